// File: rtl/memory_responder_if.sv
// Request/response bundle between the memory datapath (master) and the memory responder (slave).
interface memory_responder_if;
  logic        MemReq;
  logic        MemWrite;
  logic [15:0] Address;
  logic [15:0] DataIn;
  logic [15:0] MemVal;
  logic        MemReady;
  logic        MemBusy;
  logic        MemErr;

  modport master (
    output MemReq, MemWrite, Address, DataIn,
    input  MemVal, MemReady, MemBusy, MemErr
  );

  modport slave (
    input  MemReq, MemWrite, Address, DataIn,
    output MemVal, MemReady, MemBusy, MemErr
  );
endinterface

// File: rtl/memory_responder.sv
// Handshaked multi-cycle memory responder: word RAM plus an I/O page (input port,
// output port, free-running cycle counter), one access at a time with fixed latency.
module memory_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clock,
  input  logic              reset,
  memory_responder_if.slave bus,
  input  logic [15:0]       io_in,
  output logic [15:0]       io_out
);

  localparam logic [16:0] RAM_TOP     = 17'd1 << DEPTH_LOG2;
  localparam logic [2:0]  WAIT_INIT   = 3'(LATENCY - 1);
  localparam logic [15:0] ADDR_IO_IN  = 16'hFFF0;
  localparam logic [15:0] ADDR_IO_OUT = 16'hFFF1;
  localparam logic [15:0] ADDR_CYCLE  = 16'hFFF2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic [2:0]            wait_cnt_q;
  logic [15:0]           addr_q;
  logic [15:0]           wdata_q;
  logic                  we_q;
  logic [15:0]           cyc_lat_q;
  logic [15:0]           cycle_q;
  logic [15:0]           memval_q;
  logic [15:0]           io_out_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  err_q;
  logic [15:0]           mem_q [0:(1 << DEPTH_LOG2) - 1];

  logic                  commit_d;
  logic                  is_ram_d;
  logic                  wr_ram_d;
  logic                  wr_io_d;
  logic                  err_d;
  logic [15:0]           rd_data_d;
  logic [DEPTH_LOG2-1:0] ram_idx_d;

  assign commit_d  = (state_q == S_WAIT) && (wait_cnt_q == 3'd0);
  assign is_ram_d  = ({1'b0, addr_q} < RAM_TOP);
  assign ram_idx_d = addr_q[DEPTH_LOG2-1:0];

  // Decode the latched request: read data, write targets and legality
  always_comb begin
    rd_data_d = 16'h0000;
    wr_ram_d  = 1'b0;
    wr_io_d   = 1'b0;
    err_d     = 1'b0;
    if (is_ram_d) begin
      rd_data_d = mem_q[ram_idx_d];
      wr_ram_d  = we_q;
    end else begin
      case (addr_q)
        ADDR_IO_IN: begin
          rd_data_d = io_in;
          err_d     = we_q;
        end
        ADDR_IO_OUT: begin
          rd_data_d = io_out_q;
          wr_io_d   = we_q;
        end
        ADDR_CYCLE: begin
          rd_data_d = cyc_lat_q;
          err_d     = we_q;
        end
        default: begin
          rd_data_d = 16'h0000;
          err_d     = 1'b1;
        end
      endcase
    end
  end

  // Transaction FSM with registered handshake outputs, I/O register and cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 3'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      we_q       <= 1'b0;
      cyc_lat_q  <= 16'h0000;
      cycle_q    <= 16'h0000;
      memval_q   <= 16'h0000;
      io_out_q   <= 16'h0000;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 16'd1;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          // DONE accepts directly so held requests stream without an IDLE bubble
          if (bus.MemReq) begin
            addr_q     <= bus.Address;
            wdata_q    <= bus.DataIn;
            we_q       <= bus.MemWrite;
            cyc_lat_q  <= cycle_q;
            wait_cnt_q <= WAIT_INIT;
            state_q    <= S_WAIT;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (commit_d) begin
            state_q <= S_DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= err_d;
            if (!we_q) begin
              memval_q <= rd_data_d;
            end
            if (wr_io_d) begin
              io_out_q <= wdata_q;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (!reset && commit_d && wr_ram_d) begin
      mem_q[ram_idx_d] <= wdata_q;
    end
  end

  assign bus.MemVal   = memval_q;
  assign bus.MemReady = ready_q;
  assign bus.MemBusy  = busy_q;
  assign bus.MemErr   = err_q;
  assign io_out       = io_out_q;

endmodule

// File: doc/memory_responder.md
# memory_responder

Memory-side responder for the CPU memory port: it accepts one load or store request at a time from the memory datapath (address, write data, write enable) and completes it after a fixed access latency. Backing storage is a word-addressed RAM plus a small memory-mapped I/O page: an input port, an output port and a free-running cycle counter. It sits directly below the memory datapath address/data muxes. It replaces the single-cycle memory with a handshaked, multi-cycle responder, so the control unit can stall on `MemBusy`.

## Interface

Parameters:
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 16-bit words at addresses 0 to 2^DEPTH_LOG2-1.
- `LATENCY`, default 2: number of WAIT cycles per access. Legal range is 1 to 7.

Ports:
- `clock`, in, 1 bit: the single clock. All state changes on its rising edge.
- `reset`, in, 1 bit: synchronous, active-high reset.
- `MemReq`, in, 1 bit: request strobe. Sampled only in IDLE or DONE.
- `MemWrite`, in, 1 bit: 1 = store, 0 = load. Sampled with `MemReq`.
- `Address`, in, 16 bits: word address. Sampled with `MemReq`.
- `DataIn`, in, 16 bits: store data. Sampled with `MemReq`.
- `io_in`, in, 16 bits: external input port, readable at 0xFFF0.
- `MemVal`, out, 16 bits: load result. Holds its value between loads.
- `MemReady`, out, 1 bit: one-cycle completion pulse.
- `MemBusy`, out, 1 bit: high while a transaction is in flight.
- `MemErr`, out, 1 bit: pulses together with `MemReady` when the access is illegal.
- `io_out`, out, 16 bits: output port register at 0xFFF1.

## Operation

- Address map:
  - RAM: Address < 2^DEPTH_LOG2. The RAM is indexed by `Address[DEPTH_LOG2-1:0]`.
  - 0xFFF0 IO_IN: read-only.
  - 0xFFF1 IO_OUT: read/write.
  - 0xFFF2 CYCLE: read-only.
  - Everything else is unmapped.
- Acceptance: when `MemReq` is 1 in IDLE or DONE, latch `Address`, `DataIn`, `MemWrite` and the current CYCLE value into request registers, then go to WAIT.
- FSM transitions:
  - IDLE: go to WAIT on `MemReq`, else stay in IDLE.
  - WAIT: load `wait_cnt` with LATENCY-1 on entry. Decrement it each cycle. Go to DONE on the cycle when `wait_cnt` is 0.
  - DONE: go to WAIT on `MemReq`, else go to IDLE.
- `MemReq` is ignored in WAIT. It is not queued.
- Store commit: a store updates RAM or `io_out` on the edge from WAIT to DONE.
- Stores to IO_IN, CYCLE or unmapped addresses are discarded. `MemErr` is 1 in DONE.
- Load data: `MemVal` loads on the edge from WAIT to DONE, with the value chosen by address:
  - RAM word.
  - `io_in` as sampled on that edge.
  - `io_out`.
  - Latched CYCLE value.
  - 0x0000 for unmapped addresses, with `MemErr` = 1.
- Stores leave `MemVal` unchanged.
- CYCLE counter: 16-bit. It is 0x0000 in the first cycle after reset deasserts and increments every cycle. It wraps from 0xFFFF to 0x0000. It is never writable.
- Read-after-write: a load to an address written by the previous transaction returns the new data. The commit always precedes the next acceptance, so no bypass is needed.
- Outputs:
  - `MemBusy` = 1 in WAIT and DONE.
  - `MemReady` = 1 only in DONE.
  - `MemErr` = 0 outside DONE.

## Timing

- The request is present in cycle 0, with the FSM in IDLE.
- Cycles 1 to LATENCY: WAIT, `MemBusy` = 1.
- Cycle LATENCY+1: DONE. `MemReady`, `MemBusy` and `MemErr` are valid, and `MemVal` holds the load result.
- Effects of a store (`io_out`, RAM) are visible from cycle LATENCY+1.
- Back-to-back throughput: with `MemReq` held high, one transaction completes every LATENCY+1 cycles. DONE flows directly into WAIT without passing through IDLE.
- Reset state, applied on any edge with `reset` = 1, including mid-transaction:
  - FSM goes to IDLE.
  - `MemVal`, `io_out` and CYCLE are cleared to 0x0000.
  - `MemReady`, `MemBusy` and `MemErr` are 0.
  - Any in-flight store is discarded.
  - RAM contents are not cleared.
- `reset` takes priority over `MemReq` when both are high on the same edge.

## Test plan

- Write then read RAM (LATENCY=2):
  - Store 0x1234 to 0x0005 -> `MemReady` high in cycle 3 only, `MemBusy` high in cycles 1 to 3.
  - Then load 0x0005 -> `MemVal` = 0x1234 in its DONE cycle, `MemErr` = 0.
- I/O page:
  - Store 0xBEEF to 0xFFF1 -> `io_out` = 0xBEEF from DONE.
  - Load 0xFFF1 -> 0xBEEF.
  - With `io_in` = 0x5A5A, load 0xFFF0 -> `MemVal` = 0x5A5A.
- Illegal accesses:
  - Load 0x8000 -> `MemVal` = 0x0000, `MemErr` = 1 for one cycle.
  - Store 0x7777 to 0xFFF2 -> `MemErr` = 1, and a subsequent CYCLE read is unaffected.
- Throughput:
  - Hold `MemReq` = 1 with stores to 0x0001, 0x0002, 0x0003 -> `MemReady` pulses in cycles 3, 6 and 9.
  - Toggle inputs during WAIT -> no effect on any transaction.
- Reset mid-operation:
  - RAM[0x0010] = 0x0001; start a store of 0xFFFF to 0x0010; assert `reset` in cycle 1.
  - -> No `MemReady`; `MemBusy` = 0 on the next cycle; `io_out` = 0x0000.
  - A later load of 0x0010 -> 0x0001.
- Counter:
  - Request a load of 0xFFF2 in cycle 10 after reset release -> `MemVal` = 0x000A.
  - Force the counter to run 65536 cycles -> the counter wraps to 0x0000.
